// File: rtl/missile_pool_if.sv
// missile_pool_if -- bundle of the fire/motion/draw signals between a missile
// pool and its surroundings (fire source, frame timing, pixel scanner, and the
// drawing/collision mux).
//
// Parameter:
//   SHOT_AMOUNT   number of slots in the attached pool; sizes active_count.
//                 It must match the SHOT_AMOUNT of the missile_pool it connects to.
//
// Signals (the direction is given as seen by the pool, which uses the slave modport):
//   startOfFrame  in   one-cycle pulse per video frame
//   fire          in   fire request (level)
//   collision     in   collision flag, aligned with missileDR
//   pixelX/Y      in   current scan pixel (11 bit)
//   shooter_X/Y   in   shooter top-left (11 bit signed)
//   missileDR     out  draw request
//   missileRGB    out  RGB332 colour
//   active_count  out  number of live missiles
//   shot_fired    out  one-cycle pulse per accepted shot
interface missile_pool_if #(
  parameter int SHOT_AMOUNT = 7
);
  localparam int CNT_W = $clog2(SHOT_AMOUNT + 1);

  logic                    startOfFrame;
  logic                    fire;
  logic                    collision;
  logic [10:0]             pixelX;
  logic [10:0]             pixelY;
  logic signed [10:0]      shooter_X;
  logic signed [10:0]      shooter_Y;
  logic                    missileDR;
  logic [7:0]              missileRGB;
  logic [CNT_W-1:0]        active_count;
  logic                    shot_fired;

  modport master (
    output startOfFrame, fire, collision, pixelX, pixelY, shooter_X, shooter_Y,
    input  missileDR, missileRGB, active_count, shot_fired
  );

  modport slave (
    input  startOfFrame, fire, collision, pixelX, pixelY, shooter_X, shooter_Y,
    output missileDR, missileRGB, active_count, shot_fired
  );
endinterface

// File: rtl/missile_pool.sv
// missile_pool -- pool of up to SHOT_AMOUNT vertically travelling missiles.
// The pool allocates slots, moves missiles once per frame, retires them when
// they leave the play field or are hit, applies the fire cooldown, and produces
// a draw request for the current scan pixel.
//
// Ports:
//   clk     system clock
//   resetN  asynchronous, active-low reset
//   bus     missile_pool_if.slave (startOfFrame, fire, collision, pixelX/Y,
//           shooter_X/Y in; missileDR, missileRGB, active_count, shot_fired out)
//
// Optional feature:
//   MISSILE_POOL_AUTOFIRE_EN  When this macro is defined, fire is level-sensitive:
//                             holding fire shoots each time cooldown allows.
//                             When it is undefined, only the rising edge of fire
//                             is used, so one press gives at most one shot.
module missile_pool #(
  parameter int          SHOT_AMOUNT   = 7,
  parameter int          DIRECTION     = 0,
  parameter int          SPEED         = 4,
  parameter int          MISSILE_W     = 2,
  parameter int          MISSILE_H     = 5,
  parameter int          SPAWN_OFF_X   = 15,
  parameter int          SPAWN_OFF_Y   = 0,
  parameter int          TOP_LIMIT     = 0,
  parameter int          BOTTOM_LIMIT  = 479,
  parameter int          COOLDOWN_W    = 4,
  parameter int          COOLDOWN      = 15,
  parameter logic [7:0]  MISSILE_COLOR = 8'h1F
) (
  input logic           clk,
  input logic           resetN,
  missile_pool_if.slave bus
);

  localparam int CNT_W    = $clog2(SHOT_AMOUNT + 1);
  // An upward missile spawns above the shooter, so its own height is subtracted.
  localparam int SPAWN_DY = (DIRECTION == 1) ? SPAWN_OFF_Y : SPAWN_OFF_Y - MISSILE_H;

  localparam logic signed [11:0] TOP_THR = 12'(TOP_LIMIT + SPEED);
  localparam logic signed [11:0] BOT_THR = 12'(BOTTOM_LIMIT - MISSILE_H);
  localparam logic signed [11:0] SPEED12 = 12'(SPEED);
  localparam logic signed [11:0] W12     = 12'(MISSILE_W);
  localparam logic signed [11:0] H12     = 12'(MISSILE_H);
  localparam logic signed [10:0] SPEED11 = 11'(SPEED);
  localparam logic signed [10:0] OFFX11  = 11'(SPAWN_OFF_X);
  localparam logic signed [10:0] DY11    = 11'(SPAWN_DY);
  localparam logic [COOLDOWN_W-1:0] CD_RELOAD = COOLDOWN_W'(COOLDOWN);

  logic [SHOT_AMOUNT-1:0] active_q, active_d;
  logic [SHOT_AMOUNT-1:0] hit_q, hit_d;
  logic [SHOT_AMOUNT-1:0] free_sel;
  logic signed [10:0]     x_q [SHOT_AMOUNT];
  logic signed [10:0]     x_d [SHOT_AMOUNT];
  logic signed [10:0]     y_q [SHOT_AMOUNT];
  logic signed [10:0]     y_d [SHOT_AMOUNT];
  logic [COOLDOWN_W-1:0]  cooldown_q, cooldown_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic signed [11:0]     px, py;
  logic                   fire_ok;
  logic                   accept;

  // All geometry is done in 12-bit signed so that edge positions cannot wrap.
  function automatic logic signed [11:0] sx(input logic signed [10:0] v);
    return {v[10], v};
  endfunction

  assign px = $signed({1'b0, bus.pixelX});
  assign py = $signed({1'b0, bus.pixelY});

`ifdef MISSILE_POOL_AUTOFIRE_EN
  assign fire_ok = bus.fire;
`else
  logic fire_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) fire_q <= 1'b0;
    else         fire_q <= bus.fire;
  end

  // An edge that is not accepted (cooldown or full pool) is simply lost.
  assign fire_ok = bus.fire & ~fire_q;
`endif

  // This isolates the lowest inactive slot as a one-hot vector; it is zero when the pool is full.
  assign free_sel = ~active_q & (active_q + SHOT_AMOUNT'(1));

  // Acceptance is combinational. The resetN term keeps shot_fired low while the pool is held in reset.
  assign accept = resetN & fire_ok & (cooldown_q == '0) & (|free_sel);

  // Per-slot next state. Collision retirement takes priority over frame motion.
  // A slot that spawns this cycle was inactive, so it is never moved on its spawn cycle.
  always_comb begin
    active_d = active_q;
    hit_d    = '0;
    for (int i = 0; i < SHOT_AMOUNT; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];

      hit_d[i] = active_q[i] &&
                 (sx(x_q[i]) <= px) && (px < sx(x_q[i]) + W12) &&
                 (sx(y_q[i]) <= py) && (py < sx(y_q[i]) + H12);

      if (active_q[i]) begin
        if (bus.collision && hit_q[i]) begin
          active_d[i] = 1'b0;
        end else if (bus.startOfFrame) begin
          if (DIRECTION == 0) begin
            if (sx(y_q[i]) < TOP_THR) active_d[i] = 1'b0;
            else                      y_d[i] = y_q[i] - SPEED11;
          end else begin
            if (sx(y_q[i]) + SPEED12 > BOT_THR) active_d[i] = 1'b0;
            else                                y_d[i] = y_q[i] + SPEED11;
          end
        end
      end else if (accept && free_sel[i]) begin
        active_d[i] = 1'b1;
        x_d[i]      = bus.shooter_X + OFFX11;
        y_d[i]      = bus.shooter_Y + DY11;
      end
    end
  end

  // The cooldown reloads on a shot. This has priority over the frame decrement.
  always_comb begin
    cooldown_d = cooldown_q;
    if (accept)
      cooldown_d = CD_RELOAD;
    else if (bus.startOfFrame && (cooldown_q != '0))
      cooldown_d = cooldown_q - COOLDOWN_W'(1);
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < SHOT_AMOUNT; i++)
      count_d = count_d + CNT_W'(active_q[i]);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active_q   <= '0;
      hit_q      <= '0;
      cooldown_q <= '0;
      count_q    <= '0;
      for (int i = 0; i < SHOT_AMOUNT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      active_q   <= active_d;
      hit_q      <= hit_d;
      cooldown_q <= cooldown_d;
      count_q    <= count_d;
      for (int i = 0; i < SHOT_AMOUNT; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  assign bus.missileDR    = |hit_q;
  assign bus.missileRGB   = MISSILE_COLOR;
  assign bus.active_count = count_q;
  assign bus.shot_fired   = accept;

endmodule

// File: tb/tb_missile_pool.sv
// tb_missile_pool -- directed self-checking bench for missile_pool.
// Three pools share clock, reset, pixel and shooter inputs:
//   A: defaults (upward, 7 slots, cooldown 15)
//   B: 2 slots, cooldown 0, downward
//   C: 7 slots, cooldown 3
// 'sel' routes fire/startOfFrame/collision to one pool and selects its outputs.
module tb_missile_pool;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  int                 sel;
  logic               fire, sof, collision;
  logic [10:0]        pixelX, pixelY;
  logic signed [10:0] shooter_X, shooter_Y;

  int errors = 0;
  int checks = 0;

`ifdef MISSILE_POOL_AUTOFIRE_EN
  localparam int HOLD_SHOTS = 3;
`else
  localparam int HOLD_SHOTS = 1;
`endif

  missile_pool_if #(.SHOT_AMOUNT(7)) bus_a ();
  missile_pool_if #(.SHOT_AMOUNT(2)) bus_b ();
  missile_pool_if #(.SHOT_AMOUNT(7)) bus_c ();

  assign bus_a.fire         = fire && (sel == 0);
  assign bus_a.startOfFrame = sof && (sel == 0);
  assign bus_a.collision    = collision && (sel == 0);
  assign bus_a.pixelX       = pixelX;
  assign bus_a.pixelY       = pixelY;
  assign bus_a.shooter_X    = shooter_X;
  assign bus_a.shooter_Y    = shooter_Y;

  assign bus_b.fire         = fire && (sel == 1);
  assign bus_b.startOfFrame = sof && (sel == 1);
  assign bus_b.collision    = collision && (sel == 1);
  assign bus_b.pixelX       = pixelX;
  assign bus_b.pixelY       = pixelY;
  assign bus_b.shooter_X    = shooter_X;
  assign bus_b.shooter_Y    = shooter_Y;

  assign bus_c.fire         = fire && (sel == 2);
  assign bus_c.startOfFrame = sof && (sel == 2);
  assign bus_c.collision    = collision && (sel == 2);
  assign bus_c.pixelX       = pixelX;
  assign bus_c.pixelY       = pixelY;
  assign bus_c.shooter_X    = shooter_X;
  assign bus_c.shooter_Y    = shooter_Y;

  missile_pool dut_a (.clk(clk), .resetN(resetN), .bus(bus_a));

  missile_pool #(.SHOT_AMOUNT(2), .COOLDOWN(0), .DIRECTION(1)) dut_b (
    .clk(clk), .resetN(resetN), .bus(bus_b));

  missile_pool #(.COOLDOWN(3)) dut_c (.clk(clk), .resetN(resetN), .bus(bus_c));

  logic dr, shot;
  int   count;
  int   rgb;

  always_comb begin
    dr    = bus_a.missileDR;
    shot  = bus_a.shot_fired;
    count = int'(bus_a.active_count);
    rgb   = int'(bus_a.missileRGB);
    if (sel == 1) begin
      dr    = bus_b.missileDR;
      shot  = bus_b.shot_fired;
      count = int'(bus_b.active_count);
      rgb   = int'(bus_b.missileRGB);
    end else if (sel == 2) begin
      dr    = bus_c.missileDR;
      shot  = bus_c.shot_fired;
      count = int'(bus_c.active_count);
      rgb   = int'(bus_c.missileRGB);
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one input vector and let combinational outputs settle (no clock edge).
  task automatic applyStimulus(input logic f, input logic s, input logic c);
    fire      = f;
    sof       = s;
    collision = c;
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      step(1);
    end
  endtask

  // missileDR shows the hit for a pixel one clock after that pixel is presented.
  task automatic probe(input string tag, input int x, input int y, input int expected);
    pixelX = 11'(x);
    pixelY = 11'(y);
    step(1);
    checkOutput(tag, int'(dr), expected);
  endtask

  task automatic press(input string tag, input int expected);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput(tag, int'(shot), expected);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int shots;
    sel = 0; fire = 0; sof = 0; collision = 0;
    pixelX = 0; pixelY = 0;
    shooter_X = 100; shooter_Y = 400;
    $display("[TB] missile_pool directed test start");

    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;
    step(1);
    checkOutput("reset_dr", int'(dr), 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_shot", int'(shot), 0);
    checkOutput("rgb", rgb, 8'h1F);

    // Single shot on pool A: spawn at (115,395).
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("shot_pulse", int'(shot), 1);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("shot_once", int'(shot), 0);
    checkOutput("count_lag", count, 0);
    step(1);
    checkOutput("count_one", count, 1);
    probe("spawn_tl", 115, 395, 1);
    probe("spawn_left", 114, 395, 0);
    probe("spawn_br", 116, 399, 1);
    probe("spawn_right", 117, 399, 0);
    probe("spawn_below", 115, 400, 0);
    probe("spawn_above", 115, 394, 0);

    frames(3);
    probe("move3_top", 115, 383, 1);
    probe("move3_above", 115, 382, 0);
    probe("move3_bot", 116, 387, 1);
    probe("move3_below", 115, 388, 0);
    checkOutput("move3_count", count, 1);

    // 95 more frames bring Y to 3; the next frame retires it (3 < 0+4).
    frames(95);
    probe("y3_top", 115, 3, 1);
    probe("y3_bot", 115, 7, 1);
    probe("y3_below", 115, 8, 0);
    checkOutput("pre_retire_count", count, 1);
    frames(1);
    checkOutput("retire_count", count, 0);
    probe("retired_y3", 115, 3, 0);
    probe("retired_y0", 115, 0, 0);

    // Two missiles on pool A, then a collision on slot 1 together with startOfFrame.
    press("fire_slot0", 1);
    press("cooldown_block", 0);
    frames(15);
    shooter_X = 300;
    press("fire_slot1", 1);
    checkOutput("count_two", count, 2);
    probe("hit_slot1", 315, 395, 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    step(1);
    pixelX = 0; pixelY = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    probe("slot1_gone", 315, 395, 0);
    probe("slot0_moved", 115, 331, 1);
    probe("slot0_above", 115, 330, 0);
    checkOutput("count_after_hit", count, 1);

    // Pool full on pool B (2 slots, cooldown 0, downward).
    sel = 1;
    shooter_X = 200; shooter_Y = 100;
    step(1);
    press("b_shot1", 1);
    shooter_X = 250;
    press("b_shot2", 1);
    press("b_full", 0);
    checkOutput("b_count_full", count, 2);
    probe("b_hit0", 215, 100, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(1);
    pixelX = 0; pixelY = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("b_count_freed", count, 1);
    shooter_X = 400;
    press("b_reuse", 1);
    probe("b_slot_reuse", 415, 100, 1);
    probe("b_slot1_kept", 265, 100, 1);
    checkOutput("b_count_refill", count, 2);
    frames(1);
    probe("b_down", 415, 104, 1);
    probe("b_down_above", 415, 103, 0);

    // Cooldown on pool C (cooldown 3): fire held across 10 back-to-back frames.
    sel = 2;
    shooter_X = 100; shooter_Y = 400;
    step(1);
    shots = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (shot) shots++;
      step(1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("c_hold_shots", shots, HOLD_SHOTS);
    frames(4);
    press("c_repress", 1);
    frames(4);
    press("c_third", 1);
    checkOutput("c_count", count, HOLD_SHOTS + 2);
    probe("c_pre_reset_dr", 115, 395, 1);

    // Asynchronous reset in the middle of a clock cycle.
    #2;
    resetN = 1'b0;
    fire   = 1'b1;
    #1;
    checkOutput("rst_dr", int'(dr), 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_shot", int'(shot), 0);
    sel = 0;
    #1;
    checkOutput("rst_a_count", count, 0);
    sel  = 2;
    fire = 1'b0;
    step(2);
    @(negedge clk);
    resetN = 1'b1;
    step(1);
    press("post_reset_shot", 1);
    checkOutput("post_reset_count", count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
